// File: rtl/adc_input_axi_write.sv
// AXI4-Lite write-channel slave for the adc_input register file.
// Accepts AW/W in any order, updates CR/DSIZE, pulses SR.PC clear, returns OKAY.
module adc_input_axi_write #(
   parameter logic [31:0] DSIZE_RST  = 32'd0,
   parameter logic [7:0]  ADDR_CR    = 8'h00,
   parameter logic [7:0]  ADDR_SR    = 8'h04,
   parameter logic [7:0]  ADDR_DSIZE = 8'h08
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic [31:0] AWADDR,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   output logic        cr_test,
   output logic [31:0] dsize,
   output logic        sr_pc_clr
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned ADDR_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HAVE_A,
      S_HAVE_W,
      S_WRITE,
      S_RESP
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                aw_rdy_c;
   logic                w_rdy_c;
   logic                aw_hs;
   logic                w_hs;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^AWADDR[31:ADDR_W];

   assign AWREADY = ARESETN & aw_rdy_c;
   assign WREADY  = ARESETN & w_rdy_c;
   assign BRESP   = 2'b00;
   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;

   // State register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state and channel-ready decode
   always_comb begin
      state_nxt = state;
      aw_rdy_c  = 1'b0;
      w_rdy_c   = 1'b0;
      BVALID    = 1'b0;
      case (state)
         S_IDLE: begin
            aw_rdy_c = 1'b1;
            w_rdy_c  = 1'b1;
            if (aw_hs && w_hs) state_nxt = S_WRITE;
            else if (aw_hs)    state_nxt = S_HAVE_A;
            else if (w_hs)     state_nxt = S_HAVE_W;
         end
         S_HAVE_A: begin
            w_rdy_c = 1'b1;
            if (w_hs) state_nxt = S_WRITE;
         end
         S_HAVE_W: begin
            aw_rdy_c = 1'b1;
            if (aw_hs) state_nxt = S_WRITE;
         end
         S_WRITE: state_nxt = S_RESP;
         S_RESP: begin
            BVALID = 1'b1;
            if (BREADY) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Beat capture and register update on the S_WRITE edge
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         cr_test   <= 1'b0;
         dsize     <= DSIZE_RST;
         sr_pc_clr <= 1'b0;
      end else begin
         sr_pc_clr <= 1'b0;
         if (aw_hs) addr_q <= AWADDR[ADDR_W-1:0];
         if (w_hs) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
         end
         if (state == S_WRITE) begin
            if (addr_q == ADDR_CR) begin
               if (wstrb_q[0]) cr_test <= wdata_q[0];
            end else if (addr_q == ADDR_SR) begin
               sr_pc_clr <= wstrb_q[0] & wdata_q[0];
            end else if (addr_q == ADDR_DSIZE) begin
               for (int i = 0; i < int'(STRB_W); i++) begin
                  if (wstrb_q[i]) dsize[8*i +: 8] <= wdata_q[8*i +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_input_axi_write.sv
// Directed self-checking bench for adc_input_axi_write.
module tb_adc_input_axi_write;

   logic        ACLK;
   logic        ARESETN;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic        cr_test;
   logic [31:0] dsize;
   logic        sr_pc_clr;

   int total = 0;
   int bad   = 0;
   int pulse_cnt = 0;

   adc_input_axi_write dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .cr_test(cr_test), .dsize(dsize), .sr_pc_clr(sr_pc_clr)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Counts cycles in which the clear pulse is seen high
   always @(negedge ACLK) if (sr_pc_clr) pulse_cnt <= pulse_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic b_handshake(input string tag);
      int n = 0;
      while (!BVALID && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_bvalid"}, 32'(BVALID), 32'd1);
      chk({tag, "_bresp"}, 32'(BRESP), 32'd0);
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      chk({tag, "_bdone"}, 32'(BVALID), 32'd0);
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      AWADDR = a; AWVALID = 1'b1;
      WDATA = d;  WSTRB = s; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      b_handshake(tag);
   endtask

   initial begin
      ARESETN = 1'b0; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0;
      WVALID = 1'b0; BREADY = 1'b0;
      tick(); tick();
      chk("rst_awready", 32'(AWREADY), 32'd0);
      chk("rst_wready", 32'(WREADY), 32'd0);
      chk("rst_bvalid", 32'(BVALID), 32'd0);
      chk("rst_dsize", dsize, 32'd0);
      chk("rst_cr", 32'(cr_test), 32'd0);
      ARESETN = 1'b1;
      #1;
      chk("idle_awready", 32'(AWREADY), 32'd1);
      chk("idle_wready", 32'(WREADY), 32'd1);

      // Simultaneous AW+W, latency to BVALID
      AWADDR = 32'h08; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      chk("lat_bvalid_write", 32'(BVALID), 32'd0);
      chk("lat_awready_write", 32'(AWREADY), 32'd0);
      tick();
      chk("lat_bvalid_resp", 32'(BVALID), 32'd1);
      chk("lat_bresp", 32'(BRESP), 32'd0);
      chk("lat_dsize", dsize, 32'hDEADBEEF);
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      chk("lat_bdone", 32'(BVALID), 32'd0);
      chk("lat_awready_next", 32'(AWREADY), 32'd1);

      // W leads AW by three cycles
      WDATA = 32'h1; WSTRB = 4'h1; WVALID = 1'b1;
      tick();
      WVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("wfirst_awready", 32'(AWREADY), 32'd1);
         chk("wfirst_wready", 32'(WREADY), 32'd0);
         if (i < 2) tick();
      end
      AWADDR = 32'h00; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      b_handshake("wfirst");
      chk("cr_set", 32'(cr_test), 32'd1);
      wr("cr0", 32'h00, 32'h0, 4'h1);
      chk("cr_clr", 32'(cr_test), 32'd0);

      // Byte strobes
      wr("strb5", 32'h08, 32'h11223344, 4'b0101);
      chk("dsize_strb5", dsize, 32'hDE22BE44);
      wr("strb0", 32'h08, 32'hFFFFFFFF, 4'b0000);
      chk("dsize_strb0", dsize, 32'hDE22BE44);

      // SR clear pulse with BREADY held low
      AWADDR = 32'h04; AWVALID = 1'b1; WDATA = 32'h1; WSTRB = 4'h1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      tick();
      chk("sr_pulse_first", 32'(sr_pc_clr), 32'd1);
      chk("sr_bvalid_0", 32'(BVALID), 32'd1);
      for (int i = 1; i < 5; i++) begin
         tick();
         chk("sr_pulse_gone", 32'(sr_pc_clr), 32'd0);
         chk("sr_bvalid_hold", 32'(BVALID), 32'd1);
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      chk("sr_bdone", 32'(BVALID), 32'd0);
      chk("sr_pulse_count", 32'(pulse_cnt), 32'd1);
      wr("sr_zero", 32'h04, 32'h0, 4'h1);
      chk("sr_zero_count", 32'(pulse_cnt), 32'd1);

      // Unmapped offset
      wr("unmapped", 32'h0C, 32'hFFFFFFFF, 4'hF);
      chk("unmapped_cr", 32'(cr_test), 32'd0);
      chk("unmapped_dsize", dsize, 32'hDE22BE44);

      // Back-to-back with valids held: second beat waits for B handshake
      AWADDR = 32'h08; AWVALID = 1'b1; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; WVALID = 1'b1;
      tick();
      WDATA = 32'h5A5A5A5A;
      tick();
      chk("b2b_first", dsize, 32'hA5A5A5A5);
      tick();
      chk("b2b_blocked_aw", 32'(AWREADY), 32'd0);
      chk("b2b_blocked_w", 32'(WREADY), 32'd0);
      chk("b2b_hold", dsize, 32'hA5A5A5A5);
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      chk("b2b_awready", 32'(AWREADY), 32'd1);
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      b_handshake("b2b_second");
      chk("b2b_second", dsize, 32'h5A5A5A5A);

      // Aliased address: upper bits ignored
      wr("alias", 32'h00000108, 32'h0000CAFE, 4'h3);
      chk("alias_dsize", dsize, 32'h5A5ACAFE);
      wr("cr_on", 32'h00, 32'h1, 4'h1);

      // Reset while in S_HAVE_A
      AWADDR = 32'h08; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      ARESETN = 1'b0;
      #1;
      chk("rstA_awready", 32'(AWREADY), 32'd0);
      chk("rstA_wready", 32'(WREADY), 32'd0);
      chk("rstA_bvalid", 32'(BVALID), 32'd0);
      chk("rstA_dsize", dsize, 32'd0);
      chk("rstA_cr", 32'(cr_test), 32'd0);
      tick();
      ARESETN = 1'b1;
      tick();
      chk("rstA_nob", 32'(BVALID), 32'd0);
      chk("rstA_idle", 32'(WREADY), 32'd1);

      // Reset while in S_RESP
      wr("pre", 32'h08, 32'h77777777, 4'hF);
      AWADDR = 32'h08; AWVALID = 1'b1; WDATA = 32'h12121212; WSTRB = 4'hF; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      tick();
      chk("rstR_inresp", 32'(BVALID), 32'd1);
      ARESETN = 1'b0;
      #1;
      chk("rstR_bvalid", 32'(BVALID), 32'd0);
      chk("rstR_dsize", dsize, 32'd0);
      tick();
      ARESETN = 1'b1;

      // Reset in S_WRITE of an SR clear: pulse is suppressed
      AWADDR = 32'h04; AWVALID = 1'b1; WDATA = 32'h1; WSTRB = 4'h1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      ARESETN = 1'b0;
      tick(); tick();
      ARESETN = 1'b1;
      tick();
      chk("rstW_nopulse", 32'(pulse_cnt), 32'd1);
      chk("rstW_nob", 32'(BVALID), 32'd0);

      wr("post", 32'h08, 32'h12345678, 4'hF);
      chk("post_dsize", dsize, 32'h12345678);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
